// File: rtl/int_inject_unit.sv
// Interrupt entry/exit sequencer. It freezes fetch, injects the controller's
// NoOp/jump words into decode, saves the return PC and tracks ISR residency.
module int_inject_unit #(
  parameter int          NOOP_CYCLES = 5,
  parameter logic [31:0] INSTR_NOOP  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic [31:0] INT_INSTR,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  input  logic        stall,
  input  logic        reti_exec,
  output logic        ACK,
  output logic [31:0] instr_out,
  output logic        pc_hold,
  output logic [31:0] epc,
  output logic        in_isr
);

  // state   | meaning
  // RUN     | normal fetch, waiting for INT
  // ENTRY   | one-cycle ACK, decode sees a NoOp, PC frozen
  // INJECT  | controller words (NoOps then jump) fed to decode, PC frozen
  // ISR_RUN | service routine fetched normally, INT ignored
  // EXIT    | one-cycle ACK after reti retires
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    ENTRY   = 3'd1,
    INJECT  = 3'd2,
    ISR_RUN = 3'd3,
    EXIT    = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(NOOP_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  inj_cnt, inj_cnt_nxt;
  logic [31:0] epc_nxt;
  logic        in_isr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      inj_cnt <= 4'd0;
      epc     <= 32'h0;
      in_isr  <= 1'b0;
    end else begin
      state   <= state_nxt;
      inj_cnt <= inj_cnt_nxt;
      epc     <= epc_nxt;
      in_isr  <= in_isr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    inj_cnt_nxt = 4'd0;
    epc_nxt     = epc;
    ACK         = 1'b0;
    pc_hold     = 1'b0;
    instr_out   = fetch_instr;
    case (state)
      RUN: begin
        // A stalled decode would drop the captured PC's word, so wait it out.
        if (INT && !stall) begin
          epc_nxt   = fetch_pc;
          state_nxt = ENTRY;
        end
      end
      ENTRY: begin
        ACK       = 1'b1;
        pc_hold   = 1'b1;
        instr_out = INSTR_NOOP;
        state_nxt = INJECT;
      end
      INJECT: begin
        pc_hold     = 1'b1;
        instr_out   = INT_INSTR;
        inj_cnt_nxt = inj_cnt;
        if (!stall) begin
          if (inj_cnt == CNT_LAST) state_nxt = ISR_RUN;
          else inj_cnt_nxt = inj_cnt + 4'd1;
        end
      end
      ISR_RUN: begin
        if (reti_exec) state_nxt = EXIT;
      end
      EXIT: begin
        ACK       = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    in_isr_nxt = (state_nxt == ISR_RUN) || (state_nxt == EXIT);
  end

endmodule
